// File: rtl/full_adder.sv
// Ripple-carry adder of per-bit full-adder cells with a combinational result
// and an enable-gated registered copy that carries a one-cycle valid flag.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             valid_q
);

    // cv[i] is the carry into bit i; cv[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   cv;
    logic [WIDTH-1:0] s;

    always_comb begin
        cv    = '0;
        s     = '0;
        cv[0] = c_in;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]    = a[i] ^ b[i] ^ cv[i];
            cv[i+1] = (a[i] & b[i]) | (cv[i] & (a[i] ^ b[i]));
        end
    end

    assign sum   = s;
    assign carry = cv[WIDTH];
    assign ovf   = cv[WIDTH] ^ cv[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                sum_q   <= s;
                carry_q <= cv[WIDTH];
                ovf_q   <= cv[WIDTH] ^ cv[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench: stimulus pushes expected captures into a queue, a monitor
// pops and compares whenever valid_q is presented; comb outputs checked inline.
module tb_full_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c_in = 1'b0;
    logic       en = 1'b0;
    logic [7:0] sum, sum_q;
    logic       carry, ovf, carry_q, ovf_q, valid_q;

    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       sum1, carry1, ovf1, sum1_q, carry1_q, ovf1_q, valid1_q;

    int unsigned passed = 0;
    int unsigned total  = 0;
    res_t        expq[$];
    res_t        last = '0;

    full_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .en(en),
        .sum(sum), .carry(carry), .ovf(ovf),
        .sum_q(sum_q), .carry_q(carry_q), .ovf_q(ovf_q), .valid_q(valid_q)
    );

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(c1), .en(en),
        .sum(sum1), .carry(carry1), .ovf(ovf1),
        .sum_q(sum1_q), .carry_q(carry1_q), .ovf_q(ovf1_q), .valid_q(valid1_q)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, overflow from signed range.
    function automatic res_t ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        res_t        r;
        int unsigned u;
        int          sg;
        u    = int'(x) + int'(y) + int'(ci);
        sg   = int'($signed(x)) + int'($signed(y)) + int'(ci);
        r.s  = u[7:0];
        r.co = u[8];
        r.ov = (sg > 127) || (sg < -128);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive at the falling edge, check comb outputs, queue any expected capture.
    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         input logic e, input logic r);
        res_t m;
        @(negedge clk);
        a = x; b = y; c_in = ci; en = e; rst = r;
        #1;
        m = ref8(x, y, ci);
        chk("comb", {23'd0, carry, ovf, sum}, {23'd0, m.co, m.ov, m.s});
        if (e && !r) expq.push_back(m);
    endtask

    // Monitor
    initial begin
        res_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_regs", {21'd0, valid_q, carry_q, ovf_q, sum_q}, 32'd0);
                last = '0;
            end else if (valid_q) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("captured", {22'd0, carry_q, ovf_q, sum_q}, {22'd0, e.co, e.ov, e.s});
                    last = e;
                end
            end else begin
                chk("held", {22'd0, carry_q, ovf_q, sum_q}, {22'd0, last.co, last.ov, last.s});
            end
        end
    end

    initial begin
        logic [2:0]  v;
        int unsigned t;
        logic        eo;
        #1;
        chk("reset_state", {21'd0, valid_q, carry_q, ovf_q, sum_q}, 32'd0);
        chk("reset_state_w1", {28'd0, valid1_q, carry1_q, ovf1_q, sum1_q}, 32'd0);

        // WIDTH=1 exhaustive truth table, 1 time unit per step, no clock needed.
        for (int unsigned i = 0; i < 8; i++) begin
            v = i[2:0];
            a1 = v[2]; b1 = v[1]; c1 = v[0];
            #1;
            t  = int'(v[2]) + int'(v[1]) + int'(v[0]);
            eo = (int'(v[0]) - int'(v[2]) - int'(v[1]) > 0) ||
                 (int'(v[0]) - int'(v[2]) - int'(v[1]) < -1);
            chk("tt_w1", {30'd0, carry1, sum1}, {30'd0, t[1:0]});
            chk("tt_w1_ovf", {31'd0, ovf1}, {31'd0, eo});
        end

        drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("ff_plus_1", {23'd0, carry, ovf, sum}, {23'd0, 1'b1, 1'b0, 8'h00});
        drive(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("7f_plus_1", {23'd0, carry, ovf, sum}, {23'd0, 1'b0, 1'b1, 8'h80});
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("all_ones_wrap", {23'd0, carry, ovf, sum}, {23'd0, 1'b1, 1'b0, 8'hFF});

        drive(8'h3C, 8'h05, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("cap_3c", {22'd0, valid_q, carry_q, sum_q}, {22'd0, 1'b1, 1'b0, 8'h42});
        drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("hold_3c", {22'd0, valid_q, carry_q, sum_q}, {22'd0, 1'b0, 1'b0, 8'h42});

        // Capture, then assert reset mid-cycle.
        drive(8'hF0, 8'h20, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {21'd0, valid_q, carry_q, ovf_q, sum_q}, 32'd0);
        a = 8'h81; b = 8'h81; c_in = 1'b1;
        #1;
        chk("comb_in_rst", {23'd0, carry, ovf, sum}, {23'd0, 1'b1, 1'b1, 8'h03});

        for (int unsigned k = 0; k < 3; k++) drive(8'h55, 8'h0A, 1'b0, 1'b1, 1'b1);
        drive(8'h90, 8'h90, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("first_cap_after_rst", {22'd0, valid_q, carry_q, ovf_q, sum_q},
            {22'd0, 1'b1, 1'b1, 1'b1, 8'h21});

        for (int unsigned k = 0; k < 200; k++)
            drive(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        chk("queue_drained", expq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        if (passed != total) $error("%0d checks did not pass", total - passed);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand and sum width in bits; legal range 1..64.
REQ-002 Port clk  input  1  sole clock; all registers update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high; clears all registered outputs.
REQ-004 Port a  input  WIDTH  first addend, unsigned.
REQ-005 Port b  input  WIDTH  second addend, unsigned.
REQ-006 Port c_in  input  1  carry-in, added at bit 0.
REQ-007 Port en  input  1  capture enable for the registered result stage.
REQ-008 Port sum  output  WIDTH  combinational sum bits.
REQ-009 Port carry  output  1  combinational carry-out of the MSB.
REQ-010 Port ovf  output  1  combinational signed overflow (two's-complement interpretation).
REQ-011 Port sum_q  output  WIDTH  registered copy of sum.
REQ-012 Port carry_q  output  1  registered copy of carry.
REQ-013 Port ovf_q  output  1  registered copy of ovf.
REQ-014 Port valid_q  output  1  high for the cycle after a capture; low otherwise.

Function
REQ-015 {carry, sum} SHALL equal a + b + c_in computed at WIDTH+1 bits, with no truncation of the carry.
REQ-016 sum, carry and ovf SHALL be purely combinational, with zero clock latency, and SHALL be independent of clk, rst and en.
REQ-017 The combinational outputs SHALL settle within the same simulation time step as any input change (delta-cycle only), with no clock required.
REQ-018 For WIDTH=1: sum = a XOR b XOR c_in; carry = (a AND b) OR (c_in AND (a XOR b)).
REQ-019 The adder SHALL be a ripple chain of per-bit full-adder cells; bit i carry-in SHALL be the carry-out of bit i-1, and bit 0 carry-in SHALL be c_in.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB; for WIDTH=1, ovf = c_in XOR carry.
REQ-021 On a rising clk edge with en=1 and rst=0: sum_q, carry_q and ovf_q SHALL load the current combinational values, and valid_q SHALL become 1.
REQ-022 On a rising clk edge with en=0 and rst=0: sum_q, carry_q and ovf_q SHALL hold their values, and valid_q SHALL become 0.
REQ-023 Registered-output latency SHALL be exactly one clk cycle from input sampling.
REQ-024 All inputs SHALL be treated as unknown-free; no X-propagation handling is required beyond the standard operator semantics.
REQ-025 All-ones operands with c_in=1 SHALL yield sum = all-ones and carry = 1, i.e. wrap-around with carry and no saturation.

Reset
REQ-026 While rst=1: sum_q=0, carry_q=0, ovf_q=0 and valid_q=0, immediately and without waiting for a clk edge.
REQ-027 rst SHALL override en; an edge with rst=1 and en=1 SHALL NOT capture.
REQ-028 rst SHALL NOT affect the combinational outputs sum, carry and ovf.
REQ-029 After rst deasserts, the first capture SHALL occur on the first rising clk edge at which en=1.

Verification
REQ-030 The bench SHALL check the WIDTH=1 exhaustive truth table, changing (a,b,c_in) every 1 time unit with no clock and checking (carry,sum) each step:
- 000->00
- 001->01
- 010->01
- 011->10
- 100->01
- 101->10
- 110->10
- 111->11
REQ-031 WIDTH=8, a=0xFF, b=0x01, c_in=0 -> sum=0x00, carry=1, ovf=0; and a=0x7F, b=0x01, c_in=0 -> sum=0x80, carry=0, ovf=1.
REQ-032 WIDTH=8, a=0x3C, b=0x05, c_in=1 with en=1 and one clk edge -> sum_q=0x42, carry_q=0, valid_q=1; the next edge with en=0 -> values held, valid_q=0.
REQ-033 Assert rst mid-cycle after a capture -> sum_q, carry_q, ovf_q and valid_q go to 0 before the next clk edge, while sum and carry still track the inputs.
REQ-034 Hold rst=1 with en=1 for 3 edges -> no capture; deassert rst, then one edge with en=1 -> result captured and valid_q=1.
REQ-035 The bench SHALL count mismatches and SHALL end with a fail status if the count is nonzero.
